// File: rtl/debug_display_pkg.sv
// Shared constants for the debug seven-segment scanner: digit geometry and the
// active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
package debug_display_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for a common-anode seven-segment digit.
module hex_to_seg7
  import debug_display_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/debug_display_scan.sv
// Time-multiplexed 4-digit hex display of one selected 16-bit debug word.
// Optional macro DEBUG_DISPLAY_SEL_DP_EN lights the decimal point on the digit whose index matches the displayed word's sel.
module debug_display_scan
  import debug_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [15:0]       in_word0,
  input  logic [15:0]       in_word1,
  input  logic [15:0]       in_word2,
  input  logic [15:0]       in_word3,
  input  logic [1:0]        sel,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap;
  logic             r_frame_done;

  logic             w_cnt_last;
  logic             w_wrap;
  logic [15:0]      w_word_sel;
  logic [3:0]       w_nib;

  assign w_cnt_last = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_wrap     = w_cnt_last && (r_idx == 2'd3);

  always_comb begin
    w_word_sel = in_word0;
    case (sel)
      2'd0: w_word_sel = in_word0;
      2'd1: w_word_sel = in_word1;
      2'd2: w_word_sel = in_word2;
      2'd3: w_word_sel = in_word3;
      default: w_word_sel = in_word0;
    endcase
  end

  // Snapshot is only refreshed at frame wrap so every digit of a frame shows one value.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_snap       <= 16'h0000;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      r_frame_done <= w_wrap;
      if (w_cnt_last) r_idx  <= r_idx + 2'd1;
      if (w_wrap)     r_snap <= w_word_sel;
    end
  end

  assign w_nib      = r_snap[{r_idx, 2'b00} +: 4];
  assign an         = ~(DIGITS'(1) << r_idx);
  assign frame_done = r_frame_done;

  hex_to_seg7 u_hex (
    .i_nib (w_nib),
    .o_seg (seg)
  );

`ifdef DEBUG_DISPLAY_SEL_DP_EN
  logic [1:0] r_sel_snap;

  always_ff @(posedge CLK) begin
    if (Reset)       r_sel_snap <= 2'd0;
    else if (w_wrap) r_sel_snap <= sel;
  end

  assign dp = (r_idx == r_sel_snap) ? 1'b0 : 1'b1;
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_debug_display_scan.sv
// Randomized bench for debug_display_scan: two instances (SCAN_DIV=4 and 1) checked every cycle against a cycle-count model.
module tb_debug_display_scan;

  localparam int DV [2] = '{4, 1};
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] w [4];
  logic [1:0]  sel;

  logic [6:0]  seg4, seg1;
  logic        dp4, dp1, fd4, fd1;
  logic [3:0]  an4, an1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  debug_display_scan #(.SCAN_DIV(4)) dut4 (
    .CLK(CLK), .Reset(Reset),
    .in_word0(w[0]), .in_word1(w[1]), .in_word2(w[2]), .in_word3(w[3]),
    .sel(sel), .seg(seg4), .dp(dp4), .an(an4), .frame_done(fd4)
  );

  debug_display_scan #(.SCAN_DIV(1)) dut1 (
    .CLK(CLK), .Reset(Reset),
    .in_word0(w[0]), .in_word1(w[1]), .in_word2(w[2]), .in_word3(w[3]),
    .sel(sel), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = edges since reset; the display is a pure function of k and the word captured at the last multiple of 4*D.
  bit          model_on = 1'b0;
  int          k    [2];
  logic [15:0] snap [2];
  logic [1:0]  ss   [2];

  always @(posedge CLK) begin
    if (Reset) begin
      model_on = 1'b1;
      for (int m = 0; m < 2; m++) begin
        k[m] = 0; snap[m] = 16'h0; ss[m] = 2'd0;
      end
    end else if (model_on) begin
      for (int m = 0; m < 2; m++) begin
        k[m]++;
        if (k[m] % (4 * DV[m]) == 0) begin
          snap[m] = w[sel];
          ss[m]   = sel;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      for (int m = 0; m < 2; m++) begin
        int         di;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        logic [6:0] a_seg;
        logic [3:0] a_an;
        logic       a_dp, a_fd;
        di    = (k[m] / DV[m]) % 4;
        e_an  = 4'hF;
        e_an[di] = 1'b0;
        e_seg = HEX[(snap[m] >> (4 * di)) & 16'hF];
`ifdef DEBUG_DISPLAY_SEL_DP_EN
        e_dp  = (int'(ss[m]) == di) ? 1'b0 : 1'b1;
`else
        e_dp  = 1'b1;
`endif
        e_fd  = (k[m] > 0) && (k[m] % (4 * DV[m]) == 0);
        a_seg = (m == 0) ? seg4 : seg1;
        a_an  = (m == 0) ? an4  : an1;
        a_dp  = (m == 0) ? dp4  : dp1;
        a_fd  = (m == 0) ? fd4  : fd1;
        check($sformatf("model_an[%0d]", m),  32'(a_an),  32'(e_an));
        check($sformatf("model_seg[%0d]", m), 32'(a_seg), 32'(e_seg));
        check($sformatf("model_dp[%0d]", m),  32'(a_dp),  32'(e_dp));
        check($sformatf("model_fd[%0d]", m),  32'(a_fd),  32'(e_fd));
        check($sformatf("one_anode[%0d]", m), 32'($countones(~a_an)), 32'd1);
      end
    end
  end

  task automatic randomize_words();
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
  endtask

  logic [6:0] lit_a [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] lit_b [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
  logic [3:0] lit_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int  pulses;
    int  n;
    bit  found;
    Reset = 1'b1;
    sel   = 2'd0;
    for (int i = 0; i < 4; i++) w[i] = 16'h0;

    repeat (3) begin
      @(negedge CLK);
      check("rst_an",  32'(an4),  32'h0000000E);
      check("rst_seg", 32'(seg4), 32'h00000040);
      check("rst_dp",  32'(dp4),  32'd1);
      check("rst_fd",  32'(fd4),  32'd0);
    end

    w[0]  = 16'h1234;
    Reset = 1'b0;
    repeat (15) @(negedge CLK);
    check("fd_before_16", 32'(fd4), 32'd0);
    @(negedge CLK);
    check("fd_at_16", 32'(fd4), 32'd1);

    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge CLK);
      check("frame1234_seg", 32'(seg4), 32'(lit_a[j / 4]));
      check("frame1234_an",  32'(an4),  32'(lit_an[j / 4]));
      if (j == 6) begin
        w[2] = 16'hABCD;
        sel  = 2'd2;
      end
    end

    @(negedge CLK);
    check("fd_at_32", 32'(fd4), 32'd1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge CLK);
      check("frameABCD_seg", 32'(seg4), 32'(lit_b[j / 4]));
    end

    pulses = 0;
    for (int c = 0; c < 160; c++) begin
      randomize_words();
      sel = 2'($urandom_range(0, 3));
      @(negedge CLK);
      if (fd4) pulses++;
    end
    check("pulses_10_frames", 32'(pulses), 32'd10);

    found = 1'b0;
    for (int c = 0; c < 32 && !found; c++) begin
      @(negedge CLK);
      if (k[0] % 16 == 9) found = 1'b1;
      else begin
        randomize_words();
        sel = 2'($urandom_range(0, 3));
      end
    end
    check("reach_idx2_cnt1", 32'(found), 32'd1);

    Reset = 1'b1;
    sel   = 2'd3;
    @(negedge CLK);
    check("midrst_an",  32'(an4),  32'h0000000E);
    check("midrst_seg", 32'(seg4), 32'h00000040);
    check("midrst_fd",  32'(fd4),  32'd0);
    Reset = 1'b0;

    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!fd4 && n < 40);
    check("fd_after_midrst", 32'(n), 32'd16);

    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
`ifdef DEBUG_DISPLAY_SEL_DP_EN
      check("dp1_sel3", 32'(dp1), 32'(an1 != 4'b0111));
`else
      check("dp1_tied", 32'(dp1), 32'd1);
`endif
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
